// File: rtl/ad_sample_ctrl.sv
// ad_sample_ctrl: ADC acquisition front end.
// Drives a divided ADC clock, waits out a blanking interval after each start,
// then captures a fixed-length frame of samples as single-cycle strobes.
// Optional overrange tracking is built when ADC_OTR_EN is defined.
module ad_sample_ctrl #(
   parameter int DIV           = 50,
   parameter int NUM_SAMPLES   = 4500,
   parameter int BLANK_SAMPLES = 0,
   parameter int DW            = 12
) (
   input  logic          clk_50M,
   input  logic          rst_n,
   input  logic          sys_start_pulse,
   input  logic [DW-1:0] adc_data,
`ifdef ADC_OTR_EN
   input  logic          adc_otr,
   output logic          ovr_flag,
`endif
   output logic          adc_clk,
   output logic          ad_valid_out,
   output logic [DW-1:0] ad_data_out,
   output logic [12:0]   sample_idx,
   output logic          busy,
   output logic          frame_done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
   localparam int BW = (BLANK_SAMPLES > 1) ? $clog2(BLANK_SAMPLES) : 1;

   localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] DIV_HALF   = CW'(DIV / 2);
   localparam logic [SW-1:0] SAMP_LAST  = SW'(NUM_SAMPLES - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_SAMPLES - 1);

   typedef enum logic [1:0] {IDLE, BLANK, CAPTURE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   div_cnt, div_nxt;
   logic [BW-1:0]   blank_cnt;
   logic [SW-1:0]   cap_cnt;
   logic            tick, accept, cap_tick, last_cap;

   // A start is taken only from IDLE and never in the frame_done cycle, so a
   // pulse landing on the final strobe cannot chain into a new frame.
   assign tick     = (div_cnt == DIV_LAST);
   assign accept   = sys_start_pulse && (state == IDLE) && !frame_done;
   assign cap_tick = (state == CAPTURE) && tick;
   assign last_cap = (cap_cnt == SAMP_LAST);
   assign busy     = (state != IDLE);

   // Divider restarts on an accepted start so the frame is phase-locked to it.
   always_comb begin
      div_nxt = div_cnt + CW'(1);
      if (accept || tick)
         div_nxt = '0;
   end

   // State register.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic: blanking is skipped entirely when BLANK_SAMPLES is 0.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (BLANK_SAMPLES > 0) ? BLANK : CAPTURE;
         BLANK:   if (tick && (blank_cnt == BLANK_LAST)) state_nxt = CAPTURE;
         CAPTURE: if (tick && last_cap) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Free-running divider; adc_clk is registered so it is high exactly while
   // div_cnt is in the lower half of the period.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         adc_clk <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         adc_clk <= (div_nxt < DIV_HALF);
      end
   end

   // Blanking and capture counters, cleared at the start of each frame.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         blank_cnt <= '0;
         cap_cnt   <= '0;
      end else if (accept) begin
         blank_cnt <= '0;
         cap_cnt   <= '0;
      end else begin
         if ((state == BLANK) && tick)
            blank_cnt <= blank_cnt + BW'(1);
         if (cap_tick)
            cap_cnt <= cap_cnt + SW'(1);
      end
   end

   // Capture at the edge ending the tick; data and index hold between strobes.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         ad_valid_out <= 1'b0;
         frame_done   <= 1'b0;
         ad_data_out  <= '0;
         sample_idx   <= '0;
      end else begin
         ad_valid_out <= cap_tick;
         frame_done   <= cap_tick && last_cap;
         if (cap_tick) begin
            ad_data_out <= adc_data;
            sample_idx  <= 13'(cap_cnt);
         end
      end
   end

`ifdef ADC_OTR_EN
   // Sticky overrange: any out-of-range sample in the frame sets it.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n)
         ovr_flag <= 1'b0;
      else if (accept)
         ovr_flag <= 1'b0;
      else if (cap_tick && adc_otr)
         ovr_flag <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_ad_sample_ctrl.sv
// tb_ad_sample_ctrl: randomized bench for ad_sample_ctrl against a timeline
// model (strobe edges derived from the start edge by arithmetic).
// Builds the overrange checks when ADC_OTR_EN is defined.
module tb_ad_sample_ctrl;

   localparam int DIV   = 50;
   localparam int NUM   = 110;
   localparam int BLANK = 3;
   localparam int DW    = 12;
   localparam int FRAME = DIV * (BLANK + NUM);

   logic          clk_50M = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] din;
   logic          adc_clk, ad_valid_out, busy, frame_done;
   logic [DW-1:0] ad_data_out;
   logic [12:0]   sample_idx;
`ifdef ADC_OTR_EN
   logic          otr;
   logic          ovr_flag;
`endif

   ad_sample_ctrl #(
      .DIV(DIV), .NUM_SAMPLES(NUM), .BLANK_SAMPLES(BLANK), .DW(DW)
   ) dut (
      .clk_50M(clk_50M),
      .rst_n(rst_n),
      .sys_start_pulse(start),
      .adc_data(din),
`ifdef ADC_OTR_EN
      .adc_otr(otr),
      .ovr_flag(ovr_flag),
`endif
      .adc_clk(adc_clk),
      .ad_valid_out(ad_valid_out),
      .ad_data_out(ad_data_out),
      .sample_idx(sample_idx),
      .busy(busy),
      .frame_done(frame_done)
   );

   always #10 clk_50M = ~clk_50M;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int            cyc = 0;
   int            t_start = 0;
   int            done_edge = -10;
   int            phase = 0;
   bit            m_active, m_valid, m_done, m_clk, m_ovr;
   logic [DW-1:0] m_data;
   int            m_idx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_valid = 0; m_done = 0; m_clk = 0; m_ovr = 0;
      m_data = '0; m_idx = 0; phase = 0; done_edge = -10;
   endtask

   // Sample number captured at edge n of the current frame, or -1.
   function automatic int cap_k(input int n);
      int first;
      if (!m_active || !rst_n) return -1;
      first = t_start + DIV * (BLANK + 1);
      if (n < first || ((n - first) % DIV) != 0) return -1;
      return (n - first) / DIV;
   endfunction

   task automatic model_edge(input int k);
      bit acc;
      acc = 0;
      m_valid = 0;
      m_done = 0;
      if (k >= 0) begin
         m_valid = 1;
         m_data = din;
         m_idx = k;
`ifdef ADC_OTR_EN
         if (otr) m_ovr = 1;
`endif
         if (k == NUM - 1) begin
            m_done = 1;
            m_active = 0;
            done_edge = cyc;
         end
      end else if (start && !m_active && cyc != done_edge + 1) begin
         acc = 1;
         m_active = 1;
         t_start = cyc;
         m_ovr = 0;
      end
      phase = acc ? 0 : (phase + 1) % DIV;
      m_clk = (phase < DIV / 2);
   endtask

   task automatic check_all();
      chk("valid", 32'(ad_valid_out), 32'(m_valid));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("busy", 32'(busy), 32'(m_active));
      chk("adc_clk", 32'(adc_clk), 32'(m_clk));
      chk("data", 32'(ad_data_out), 32'(m_data));
      chk("sample_idx", 32'(sample_idx), 32'(m_idx));
`ifdef ADC_OTR_EN
      chk("ovr_flag", 32'(ovr_flag), 32'(m_ovr));
`endif
   endtask

   // One clock: drive inputs, advance model at the edge, check 1 ns later.
   task automatic step(input bit st);
      int k;
      din   = DW'($urandom);
      start = st;
      k = cap_k(cyc + 1);
`ifdef ADC_OTR_EN
      otr = (k < 0) ? 1'($urandom) : (k == 7);
`endif
      @(posedge clk_50M);
      cyc++;
      if (!rst_n) model_reset();
      else model_edge(k);
      #1;
      check_all();
   endtask

   task automatic run_frame(input bit noise, input bit poke10);
      int n;
      bit st;
      n = 0;
      while (!m_done && n < FRAME + 20) begin
         st = 0;
         if (noise) st = ($urandom_range(0, 7) == 0);
         if (poke10 && m_valid && m_idx == 10) st = 1;
         step(st);
         n++;
      end
      chk("frame_done_seen", 32'(frame_done), 32'd1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      start = 1'b0;
      din   = '0;
`ifdef ADC_OTR_EN
      otr   = 1'b0;
`endif
      model_reset();
      // 100 ns of reset
      for (int i = 0; i < 5; i++) step(0);
      rst_n = 1'b1;
      for (int i = 0; i < 137; i++) step(0);

      // frame A: extra starts at sample 10 and on the frame_done cycle
      step(1);
      run_frame(0, 1);
      step(1);
      for (int i = 0; i < 20; i++) step(0);

      // frame B with random start noise, then a start one cycle after done
      step(1);
      run_frame(1, 0);
      step(0);
      step(1);

      // frame C: reset asynchronously once sample 100 is out
      n = 0;
      while (!(m_valid && m_idx == 100) && n < FRAME + 20) begin
         step($urandom_range(0, 7) == 0);
         n++;
      end
      chk("reached_idx100", 32'(sample_idx), 32'd100);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      for (int i = 0; i < 3; i++) step(0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step(0);

      // frame D: full frame from index 0, then a start clears overrange
      step(1);
      run_frame(1, 0);
      for (int i = 0; i < 3; i++) step(0);
      step(1);
      for (int i = 0; i < 5; i++) step(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
